// File: rtl/segasys1_sound_latch_pkg.sv
// Shared definitions for the System 1 sound command path: NMI states,
// sound latch address nibble and command FIFO depth.
package segasys1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } nmi_state_t;

  localparam logic [3:0]  SND_LATCH_NIBBLE = 4'hE;
  localparam int unsigned SND_FIFO_DEPTH   = 4;

endpackage

// File: rtl/segasys1_sound_latch_if.sv
// Sound CPU read bus towards the command latch; master is the sound CPU side.
interface segasys1_sound_latch_if;
  logic [15:0] SCPU_AD;
  logic        SCPU_MREQ;
  logic        SCPU_RD;
  logic        LATCH_CS;
  logic [7:0]  LATCH_DO;

  modport master (output SCPU_AD, SCPU_MREQ, SCPU_RD, input LATCH_CS, LATCH_DO);
  modport slave  (input SCPU_AD, SCPU_MREQ, SCPU_RD, output LATCH_CS, LATCH_DO);
endinterface

// File: rtl/segasys1_sound_latch_cmdfifo.sv
// 4-entry command FIFO; head shows the oldest entry, or the last popped byte when empty.
module segasys1_cmdfifo
  import segasys1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       empty,
  output logic       full,
  output logic [7:0] head
);

  localparam int unsigned PW = $clog2(SND_FIFO_DEPTH);

  logic [7:0]    mem [SND_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [7:0]    last_q;
  logic          accept, take;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(SND_FIFO_DEPTH));
  assign take   = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept then.
  assign accept = push & (~full | take);
  assign head   = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SND_FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (take) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, take})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/segasys1_sound_latch.sv
// Main-to-sound CPU command latch with NMI handshake and periodic INT.
// Define SEGASYS1_SNDFIFO_EN to replace the single latch with a 4-entry FIFO.
module segasys1_sound_latch
  import segasys1_pkg::*;
#(
  parameter int unsigned INT_PERIOD = 200000,
  parameter int unsigned INT_WIDTH  = 256,
  parameter int unsigned NMI_GAP    = 32
) (
  input  logic                        CLK48M,
  input  logic                        RESET,
  input  logic                        SNDRQ,
  input  logic [7:0]                  SNDNO,
  segasys1_sound_latch_if.slave       bus,
  output logic                        SCPU_NMI,
  output logic                        SCPU_INT,
  output logic                        OVERRUN
);

  localparam int unsigned GAP_W    = $clog2(NMI_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(NMI_GAP - 1);
  localparam int unsigned INT_W    = $clog2(INT_PERIOD);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(INT_PERIOD - 1);

  logic       cs, cs_q, pop, pending, push_drop;
  logic [7:0] head, do_q;

  assign cs           = (bus.SCPU_AD[15:12] == SND_LATCH_NIBBLE) & bus.SCPU_MREQ & bus.SCPU_RD;
  assign bus.LATCH_CS = cs;
  assign bus.LATCH_DO = do_q;
  assign pop          = cs_q & ~cs & pending;

  // Output byte is frozen for the whole read so a concurrent push cannot tear it.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      cs_q <= 1'b0;
      do_q <= '0;
    end else begin
      cs_q <= cs;
      if (!cs) do_q <= head;
    end
  end

`ifdef SEGASYS1_SNDFIFO_EN
  logic empty, full;

  segasys1_cmdfifo u_fifo (
    .clk   (CLK48M),
    .rst   (RESET),
    .push  (SNDRQ),
    .din   (SNDNO),
    .pop   (pop),
    .empty (empty),
    .full  (full),
    .head  (head)
  );

  assign pending   = ~empty;
  assign push_drop = SNDRQ & full & ~pop;
`else
  logic       pending_q;
  logic [7:0] data_q;

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      pending_q <= 1'b0;
      data_q    <= '0;
    end else begin
      if (SNDRQ) data_q <= SNDNO;
      pending_q <= SNDRQ | (pending_q & ~pop);
    end
  end

  assign pending   = pending_q;
  assign head      = data_q;
  assign push_drop = SNDRQ & pending_q & ~pop;
`endif

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) OVERRUN <= 1'b0;
    else if (push_drop) OVERRUN <= 1'b1;
  end

  nmi_state_t       nmi_state;
  logic [GAP_W-1:0] gap_cnt;

  // ASSERT also leaves when the store drains without a pop, so NMI never sticks.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      nmi_state <= IDLE;
      gap_cnt   <= '0;
      SCPU_NMI  <= 1'b0;
    end else begin
      case (nmi_state)
        IDLE: begin
          if (pending) begin
            nmi_state <= ASSERT;
            SCPU_NMI  <= 1'b1;
          end
        end
        ASSERT: begin
          if (pop || !pending) begin
            nmi_state <= GAP;
            SCPU_NMI  <= 1'b0;
            gap_cnt   <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) nmi_state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          nmi_state <= IDLE;
          SCPU_NMI  <= 1'b0;
        end
      endcase
    end
  end

  logic [INT_W-1:0] int_cnt;

  // INT is registered from the pre-increment count so reset leaves it low.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      int_cnt  <= '0;
      SCPU_INT <= 1'b0;
    end else begin
      int_cnt  <= (int_cnt == INT_LAST) ? '0 : int_cnt + 1'b1;
      SCPU_INT <= (32'(int_cnt) < INT_WIDTH);
    end
  end

endmodule

// File: doc/segasys1_sound_latch.md
SEGASYS1_SOUND_LATCH -- requirements
Module: segasys1_sound_latch

Interface
REQ-001 Parameter INT_PERIOD, default 200000, CLK48M cycles between periodic sound-CPU interrupts (about 240 Hz).
REQ-002 Parameter INT_WIDTH, default 256, CLK48M cycles that SCPU_INT stays asserted per period.
REQ-003 Parameter NMI_GAP, default 32, minimum CLK48M cycles SCPU_NMI stays low between two assertions.
REQ-004 CLK48M  in  1  system clock; all logic on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 SNDRQ  in  1  one-cycle command strobe from the main CPU side.
REQ-007 SNDNO  in  8  command byte, valid while SNDRQ=1.
REQ-008 SCPU_AD  in  16  sound CPU address.
REQ-009 SCPU_MREQ  in  1  sound CPU memory request, active-high.
REQ-010 SCPU_RD  in  1  sound CPU read strobe, active-high.
REQ-011 SCPU_NMI  out  1  NMI request to the sound CPU, active-high.
REQ-012 SCPU_INT  out  1  periodic maskable interrupt request, active-high.
REQ-013 LATCH_CS  out  1  latch read select for the sound CPU data selector.
REQ-014 LATCH_DO  out  8  command byte presented to the sound CPU.
REQ-015 OVERRUN  out  1  sticky flag: a command was lost.

Function
REQ-016 LATCH_CS shall equal (SCPU_AD[15:12]==4'hE) & SCPU_MREQ & SCPU_RD, combinationally.
REQ-017 LATCH_DO shall present the oldest pending command, or the last popped value when nothing is pending, and shall stay stable for the entire read.
REQ-018 A pop shall occur on the CLK48M edge where LATCH_CS falls from 1 to 0 (registered edge detect), so each read consumes exactly one command.
REQ-019 A read with nothing pending shall return the last popped value, pop nothing and leave all state unchanged.
REQ-020 The NMI state machine shall have states IDLE, ASSERT and GAP.
- IDLE -> ASSERT when a command is pending.
- ASSERT -> GAP on a pop.
- GAP -> IDLE after NMI_GAP cycles.
- SCPU_NMI=1 only in ASSERT.
REQ-021 A 1-cycle SNDRQ pulse that arrives in IDLE shall raise SCPU_NMI on the second CLK48M edge after the SNDRQ edge, i.e. with 1 cycle of latency.
REQ-022 A free-running counter shall wrap from INT_PERIOD-1 to 0, and SCPU_INT shall be 1 while the counter is below INT_WIDTH.
REQ-023 When SNDRQ and a pop occur in the same cycle, both shall take effect, and the pop shall remove the old head, never the byte being pushed.
REQ-024 A push into a full store shall be dropped and set OVERRUN, which shall stay set until RESET.

Reset
REQ-025 On RESET:
- SCPU_NMI=0 and SCPU_INT=0.
- LATCH_DO=8'h00 and OVERRUN=0.
- Store empty, NMI FSM in IDLE, interval counter at 0, edge-detect register cleared.
REQ-026 A RESET asserted mid-read or mid-NMI shall abort immediately with no pop, and no NMI shall follow after release unless a new SNDRQ arrives.

Configuration
REQ-027 With macro SEGASYS1_SNDFIFO_EN defined, the store shall be a 4-entry FIFO (2-bit pointers plus count), and OVERRUN shall be set only when a 5th unread command arrives.
REQ-028 Without SEGASYS1_SNDFIFO_EN, the store shall be a single latch plus a pending flag:
- A push while pending shall overwrite the byte and set OVERRUN.
- A push in the same cycle as a pop shall leave the new byte pending.

Structure
REQ-029 A shared package segasys1_pkg shall hold the NMI state enum, the sound latch address nibble 4'hE and the FIFO depth constant 4.
REQ-030 The FIFO shall be the sub-module segasys1_cmdfifo, instantiated only when SEGASYS1_SNDFIFO_EN is defined.

Verification
REQ-031 SNDRQ with SNDNO=8'h5A, then a sound CPU read at $E000 -> SCPU_NMI=1 one cycle later; read returns 8'h5A; NMI drops on read release; NMI FSM reaches IDLE after 32 cycles.
REQ-032 FIFO mode: push 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with no reads -> OVERRUN=1; four reads return 8'h01 to 8'h04; NMI re-asserts after each 32-cycle gap.
REQ-033 Latch mode: push 8'h11 then 8'h22 before any read -> OVERRUN=1; a single read returns 8'h22; no second NMI follows.
REQ-034 SNDRQ with 8'h77 asserted on the same edge LATCH_CS falls while 8'h66 is pending -> pop removes 8'h66; 8'h77 stays pending; NMI re-asserts after the gap.
REQ-035 Run 2*INT_PERIOD cycles -> exactly 2 SCPU_INT pulses, each 256 cycles wide, starting 200000 cycles apart.
REQ-036 Assert RESET during ASSERT with 2 entries pending -> all outputs at reset values; no NMI after release until a new SNDRQ.
